// File: rtl/link_cond_pkg.sv
// link_cond_pkg -- shared definitions for the link conditioner.
//   lc_state_e   : link FSM state encoding (idle / acquiring / locked)
//   LC_*         : default parameter values for link_cond
//   lc_abs_diff  : unsigned absolute difference of two 32-bit periods
package link_cond_pkg;

  typedef enum logic [1:0] {
    LC_IDLE    = 2'd0,
    LC_ACQUIRE = 2'd1,
    LC_LOCKED  = 2'd2
  } lc_state_e;

  localparam int unsigned LC_CLK_HZ      = 32'd100_000_000;
  localparam int unsigned LC_FILT_LEN    = 32'd4;
  localparam int unsigned LC_TIMEOUT_CYC = 32'd250_000;
  localparam int unsigned LC_MIN_PER     = 32'd1_000;
  localparam int unsigned LC_MAX_PER     = 32'd10_000;
  localparam int unsigned LC_TOL_CYC     = 32'd8;
  localparam int unsigned LC_LOCK_CNT    = 32'd4;

  // Larger minus smaller, so neither ordering of the operands can wrap.
  function automatic logic [31:0] lc_abs_diff(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (a >= b) begin
      r = a - b;
    end else begin
      r = b - a;
    end
    return r;
  endfunction

endpackage

// File: rtl/link_cond_if.sv
// link_cond_if -- signal bundle between the power-link front end and link_cond.
//   link_raw   : raw comparator output (driven by master)
//   link       : synchronised, deglitched link level
//   swiptAlive : link edges are arriving
//   freq_rdy   : link frequency is locked
//   period     : last accepted period in clk cycles
//   f_meas     : measured frequency in Hz (only with LINK_COND_FREQ_EN)
// Modports: master = link source / observer, slave = link_cond.
// Optional feature macro: LINK_COND_FREQ_EN.
interface link_cond_if;

  logic        link_raw;
  logic        link;
  logic        swiptAlive;
  logic        freq_rdy;
  logic [31:0] period;
`ifdef LINK_COND_FREQ_EN
  logic [31:0] f_meas;

  modport master (output link_raw, input link, input swiptAlive, input freq_rdy,
                  input period, input f_meas);
  modport slave  (input link_raw, output link, output swiptAlive, output freq_rdy,
                  output period, output f_meas);
`else
  modport master (output link_raw, input link, input swiptAlive, input freq_rdy,
                  input period);
  modport slave  (input link_raw, output link, output swiptAlive, output freq_rdy,
                  output period);
`endif

endinterface

// File: rtl/link_cond_seq_div.sv
// seq_div -- 32-bit unsigned restoring divider, one quotient bit per cycle.
//   clk, rst      : clock, synchronous active-high reset (aborts a divide)
//   start_i       : load operands and (re)start; wins over a divide in flight
//   dividend_i    : numerator, divisor_i : denominator
//   busy_o        : divide in progress
//   done_o        : one-cycle pulse, quotient_o valid in that cycle
//   quotient_o    : result, held until the next start
module seq_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o
);

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] rem_sh_s;
  logic [32:0] trial_s;
  logic        ge_s;

  // Trial subtraction: the dividend is shifted out of quo_q into the remainder.
  always_comb begin
    rem_sh_s = {rem_q, quo_q[31]};
    trial_s  = rem_sh_s - {1'b0, dvs_q};
    ge_s     = ~trial_s[32];
  end

  // Next-state for operands, remainder, quotient and iteration count.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = 6'd32;
      rem_d  = 32'd0;
      quo_d  = dividend_i;
      dvs_d  = divisor_i;
    end else if (busy_q) begin
      rem_d = ge_s ? trial_s[31:0] : rem_sh_s[31:0];
      quo_d = {quo_q[30:0], ge_s};
      cnt_d = cnt_q - 6'd1;
      if (cnt_q == 6'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= 6'd0;
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      dvs_q  <= 32'd0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/link_cond.sv
// link_cond -- power-link conditioner: synchronises and deglitches the raw
// comparator output, measures the period between rising edges and tracks
// whether the link is alive and frequency-locked.
//   clk        : system clock (rising edge)
//   rst        : synchronous active-high reset
//   bus        : link_cond_if.slave (link_raw in; link, swiptAlive, freq_rdy,
//                period and optionally f_meas out)
// Optional feature macro: LINK_COND_FREQ_EN adds f_meas = CLK_HZ / period,
// computed by a seq_div instance.
module link_cond
  import link_cond_pkg::*;
#(
  parameter int unsigned CLK_HZ      = LC_CLK_HZ,
  parameter int unsigned FILT_LEN    = LC_FILT_LEN,
  parameter int unsigned TIMEOUT_CYC = LC_TIMEOUT_CYC,
  parameter int unsigned MIN_PER     = LC_MIN_PER,
  parameter int unsigned MAX_PER     = LC_MAX_PER,
  parameter int unsigned TOL_CYC     = LC_TOL_CYC,
  parameter int unsigned LOCK_CNT    = LC_LOCK_CNT
) (
  input  logic       clk,
  input  logic       rst,
  link_cond_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = LC_IDLE;
  localparam logic [1:0] ST_ACQUIRE = LC_ACQUIRE;
  localparam logic [1:0] ST_LOCKED  = LC_LOCKED;

  localparam int FC_W  = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int STB_W = (LOCK_CNT > 0) ? $clog2(LOCK_CNT + 1) : 1;

  logic             sync1_q, sync2_q;
  logic             link_q, link_d;
  logic [FC_W-1:0]  filt_cnt_q, filt_cnt_d;
  logic             link_prev_q;
  logic             rise_s;
  logic [31:0]      edge_cnt_q, edge_cnt_d;
  logic             timeout_s;
  logic             in_range_s;
  logic             stable_per_s;
  logic             accept_s;
  logic [1:0]       state_q, state_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic             ref_valid_q, ref_valid_d;
  logic [31:0]      period_q, period_d;
  logic             alive_q, rdy_q;

  // Two-flop synchroniser for the asynchronous comparator output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.link_raw;
      sync2_q <= sync1_q;
    end
  end

  // Deglitch: flip link only when FILT_LEN samples in a row differ from it.
  always_comb begin
    link_d     = link_q;
    filt_cnt_d = filt_cnt_q;
    if (sync2_q != link_q) begin
      if (filt_cnt_q == FC_W'(FILT_LEN - 1)) begin
        link_d     = sync2_q;
        filt_cnt_d = FC_W'(0);
      end else begin
        filt_cnt_d = filt_cnt_q + FC_W'(1);
      end
    end else begin
      filt_cnt_d = FC_W'(0);
    end
  end

  // Filter state and previous link level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_q      <= 1'b0;
      filt_cnt_q  <= FC_W'(0);
      link_prev_q <= 1'b0;
    end else begin
      link_q      <= link_d;
      filt_cnt_q  <= filt_cnt_d;
      link_prev_q <= link_q;
    end
  end

  assign rise_s = link_q & ~link_prev_q;

  // Edge counter restarts at 1 after each edge, so on the next edge it holds
  // exactly the number of cycles between the two edges.
  always_comb begin
    if (rise_s) begin
      edge_cnt_d = 32'd1;
    end else if (edge_cnt_q != 32'hFFFF_FFFF) begin
      edge_cnt_d = edge_cnt_q + 32'd1;
    end else begin
      edge_cnt_d = edge_cnt_q;
    end
  end

  // Period classification against range and the previous accepted period.
  always_comb begin
    timeout_s    = (edge_cnt_q == 32'(TIMEOUT_CYC));
    in_range_s   = (edge_cnt_q >= 32'(MIN_PER)) && (edge_cnt_q <= 32'(MAX_PER));
    stable_per_s = (lc_abs_diff(edge_cnt_q, period_q) <= 32'(TOL_CYC));
  end

  // Link FSM. The first accepted period after acquisition has nothing to be
  // compared with, so it opens a stable run on its own (ref_valid_q = 0).
  always_comb begin
    state_d     = state_q;
    stable_d    = stable_q;
    ref_valid_d = ref_valid_q;
    accept_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (timeout_s) begin
          stable_d = STB_W'(0);
        end else if (rise_s) begin
          state_d     = ST_ACQUIRE;
          stable_d    = STB_W'(0);
          ref_valid_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACQUIRE, ST_LOCKED: begin
        if (timeout_s) begin
          state_d     = ST_IDLE;
          stable_d    = STB_W'(0);
          ref_valid_d = 1'b0;
        end else if (rise_s) begin
          if (in_range_s) begin
            accept_s    = 1'b1;
            ref_valid_d = 1'b1;
            if (!ref_valid_q || stable_per_s) begin
              if (stable_q < STB_W'(LOCK_CNT)) begin
                stable_d = stable_q + STB_W'(1);
              end else begin
                stable_d = stable_q;
              end
            end else begin
              stable_d = STB_W'(0);
            end
          end else begin
            stable_d = STB_W'(0);
          end
          if (stable_d >= STB_W'(LOCK_CNT)) begin
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_ACQUIRE;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        stable_d    = STB_W'(0);
        ref_valid_d = 1'b0;
      end
    endcase
  end

  // Accepted period is captured the cycle after its edge.
  always_comb begin
    if (accept_s) begin
      period_d = edge_cnt_q;
    end else begin
      period_d = period_q;
    end
  end

  // Measurement and FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q  <= 32'd0;
      state_q     <= ST_IDLE;
      stable_q    <= STB_W'(0);
      ref_valid_q <= 1'b0;
      period_q    <= 32'd0;
    end else begin
      edge_cnt_q  <= edge_cnt_d;
      state_q     <= state_d;
      stable_q    <= stable_d;
      ref_valid_q <= ref_valid_d;
      period_q    <= period_d;
    end
  end

  // Status flags follow the FSM state with one cycle of delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      alive_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      alive_q <= (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED);
      rdy_q   <= (state_q == ST_LOCKED);
    end
  end

  assign bus.link       = link_q;
  assign bus.swiptAlive = alive_q;
  assign bus.freq_rdy   = rdy_q;
  assign bus.period     = period_q;

`ifdef LINK_COND_FREQ_EN
  logic        div_busy_s;
  logic        div_done_s;
  logic [31:0] div_quot_s;
  logic [31:0] f_meas_q, f_meas_d;

  // Each accepted period (re)starts CLK_HZ / period.
  seq_div u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (accept_s),
    .dividend_i (32'(CLK_HZ)),
    .divisor_i  (edge_cnt_q),
    .busy_o     (div_busy_s),
    .done_o     (div_done_s),
    .quotient_o (div_quot_s)
  );

  // Take the quotient only from a divide that actually finished.
  always_comb begin
    if (div_done_s && !div_busy_s) begin
      f_meas_d = div_quot_s;
    end else begin
      f_meas_d = f_meas_q;
    end
  end

  // Frequency result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_meas_q <= 32'd0;
    end else begin
      f_meas_q <= f_meas_d;
    end
  end

  assign bus.f_meas = f_meas_q;
`else
  // CLK_HZ only feeds the frequency divider, which is not built here.
  logic unused_clk_hz_s;
  assign unused_clk_hz_s = ^(32'(CLK_HZ));
`endif

endmodule

// File: tb/tb_link_cond.sv
`timescale 1ns/1ps
// Randomised bench for link_cond, scaled so a full run stays short:
// CLK_HZ = 10.25 MHz makes a 250-cycle period exactly 41 kHz.
module tb_link_cond;

  localparam int T_CLK_HZ  = 10_250_000;
  localparam int T_FILT    = 4;
  localparam int T_TIMEOUT = 3000;
  localparam int T_MIN     = 100;
  localparam int T_MAX     = 1000;
  localparam int T_TOL     = 8;
  localparam int T_LOCK    = 4;

  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;

  logic clk = 1'b0;
  logic rst;

  link_cond_if bus_if ();

  link_cond #(
    .CLK_HZ      (T_CLK_HZ),
    .FILT_LEN    (T_FILT),
    .TIMEOUT_CYC (T_TIMEOUT),
    .MIN_PER     (T_MIN),
    .MAX_PER     (T_MAX),
    .TOL_CYC     (T_TOL),
    .LOCK_CNT    (T_LOCK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: link state tracked per rising edge of link_raw.
  int          m_state;
  int          m_stable;
  int          since_rise;
  bit          m_have_ref;
  logic [31:0] m_period;
  logic [31:0] m_fmeas;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state    = M_IDLE;
    m_stable   = 0;
    m_have_ref = 1'b0;
    m_period   = 32'd0;
    m_fmeas    = 32'd0;
    since_rise = 0;
  endtask

  // One rising edge of link_raw; the measured period is the time since the last one.
  task automatic model_rise();
    int meas;
    int d;
    if (m_state == M_IDLE) begin
      m_state    = M_ACQ;
      m_stable   = 0;
      m_have_ref = 1'b0;
    end else begin
      meas = since_rise;
      if (meas >= T_MIN && meas <= T_MAX) begin
        d = meas - int'(m_period);
        if (d < 0) d = -d;
        if (!m_have_ref || d <= T_TOL) m_stable = m_stable + 1;
        else m_stable = 0;
        m_period   = meas;
        m_have_ref = 1'b1;
        m_fmeas    = T_CLK_HZ / meas;
      end else begin
        m_stable = 0;
      end
      m_state = (m_stable >= T_LOCK) ? M_LOCK : M_ACQ;
    end
    since_rise = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    since_rise++;
    if (m_state != M_IDLE && since_rise == T_TIMEOUT) begin
      m_state  = M_IDLE;
      m_stable = 0;
    end
  endtask

  task automatic check_flags(input string tag);
    check_val({tag, "_alive"}, bus_if.swiptAlive, (m_state != M_IDLE) ? 32'd1 : 32'd0);
    check_val({tag, "_rdy"},   bus_if.freq_rdy,   (m_state == M_LOCK) ? 32'd1 : 32'd0);
  endtask

  // One period of p cycles (high p/2), optional 3-cycle glitch in the low
  // phase, optional reset pulse rst_at cycles after the rising edge.
  task automatic send_period(input int p, input bit glitch, input int rst_at);
    int h;
    h = p / 2;
    bus_if.link_raw = 1'b1;
    model_rise();
    for (int i = 1; i <= p; i++) begin
      tick();
      if (i == h) bus_if.link_raw = 1'b0;
      if (glitch && i == h + 20) bus_if.link_raw = 1'b1;
      if (glitch && i == h + 23) bus_if.link_raw = 1'b0;
      if (i == 12) begin
        check_val("link_high", bus_if.link, 32'd1);
        check_flags("edge");
        check_val("period", bus_if.period, m_period);
      end
      if (i == h + 12) check_val("link_low", bus_if.link, 32'd0);
`ifdef LINK_COND_FREQ_EN
      if (i == 46) check_val("f_meas", bus_if.f_meas, m_fmeas);
`endif
      if (rst_at > 0 && i == rst_at + 1) begin
        check_val("rst_link",  bus_if.link,       32'd0);
        check_val("rst_alive", bus_if.swiptAlive, 32'd0);
        check_val("rst_rdy",   bus_if.freq_rdy,   32'd0);
        check_val("rst_per",   bus_if.period,     32'd0);
`ifdef LINK_COND_FREQ_EN
        check_val("rst_fmeas", bus_if.f_meas,     32'd0);
`endif
        rst = 1'b0;
        model_reset();
      end
      if (rst_at > 0 && i == rst_at) begin
        rst = 1'b1;
        bus_if.link_raw = 1'b0;
      end
    end
  endtask

  task automatic hold_low(input int n);
    bus_if.link_raw = 1'b0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (since_rise == T_TIMEOUT - 1) check_flags("pre_timeout");
      if (since_rise == T_TIMEOUT + 20) check_flags("post_timeout");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.link_raw = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus_if.link_raw = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("reset_link",  bus_if.link,       32'd0);
    check_val("reset_alive", bus_if.swiptAlive, 32'd0);
    check_val("reset_rdy",   bus_if.freq_rdy,   32'd0);
    check_val("reset_per",   bus_if.period,     32'd0);
`ifdef LINK_COND_FREQ_EN
    check_val("reset_fmeas", bus_if.f_meas,     32'd0);
`endif
    rst = 1'b0;

    // 3-cycle glitches on a quiet line must never reach link.
    for (int g = 0; g < 5; g++) begin
      bus_if.link_raw = 1'b1;
      repeat (3) begin tick(); check_val("glitch_link", bus_if.link, 32'd0); end
      bus_if.link_raw = 1'b0;
      repeat (10) begin tick(); check_val("glitch_link", bus_if.link, 32'd0); end
    end
    repeat (10) tick();
    check_val("glitch_alive", bus_if.swiptAlive, 32'd0);

    // 41 kHz: lock after the 5th rising edge.
    for (int k = 0; k < 8; k++) send_period(250, 1'b0, 0);
    check_val("lock41_period", bus_if.period, 32'd250);
    check_val("lock41_rdy", bus_if.freq_rdy, 32'd1);

    // Jittered 41 kHz, sometimes beyond tolerance, with random glitches.
    for (int k = 0; k < 20; k++)
      send_period(250 + int'($urandom_range(12, 0)) - 6, 1'(($urandom_range(1, 0))), 0);

    // One long period drops lock, then relock.
    for (int k = 0; k < 6; k++) send_period(250, 1'b0, 0);
    send_period(271, 1'b0, 0);
    for (int k = 0; k < 7; k++) send_period(250, 1'b0, 0);

    // Range boundaries.
    for (int k = 0; k < 6; k++) send_period(100, 1'b0, 0);
    for (int k = 0; k < 6; k++) send_period(1000, 1'b0, 0);
    for (int k = 0; k < 2; k++) send_period(99, 1'b0, 0);
    for (int k = 0; k < 2; k++) send_period(1001, 1'b0, 0);
    for (int k = 0; k < 6; k++) send_period(250, 1'b0, 0);

    // Random base periods with small jitter.
    for (int g = 0; g < 4; g++) begin
      base = int'($urandom_range(1005, 95));
      for (int k = 0; k < 5; k++)
        send_period(base + int'($urandom_range(10, 0)) - 5, 1'b0, 0);
    end

    // Lock, then silence: flags drop after the timeout.
    for (int k = 0; k < 6; k++) send_period(250, 1'b0, 0);
    hold_low(T_TIMEOUT + 50);

    // Too fast (200 kHz equivalent): alive but never locked, period stays 0.
    do_reset();
    for (int k = 0; k < 8; k++) send_period(50, 1'b0, 0);
    check_val("fast_period", bus_if.period, 32'd0);
    check_val("fast_rdy", bus_if.freq_rdy, 32'd0);
    check_val("fast_alive", bus_if.swiptAlive, 32'd1);

    // Reset pulse while a divide is running.
    for (int k = 0; k < 6; k++) send_period(250, 1'b0, 0);
    send_period(250, 1'b0, 20);
    for (int k = 0; k < 6; k++) send_period(250, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/link_cond.md
LINK_COND -- requirements
Module: link_cond

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter FILT_LEN, default 4, consecutive identical samples required to change the filtered level.
REQ-003 Parameter TIMEOUT_CYC, default 250000, cycles without a rising edge before the link is declared dead.
REQ-004 Parameter MIN_PER, default 1000, smallest accepted period in cycles (100 kHz).
REQ-005 Parameter MAX_PER, default 10000, largest accepted period in cycles (10 kHz).
REQ-006 Parameter TOL_CYC, default 8, maximum period difference between consecutive periods that still counts as stable.
REQ-007 Parameter LOCK_CNT, default 4, number of consecutive stable periods needed for lock.
REQ-008 Port clk, input, 1, single system clock; all logic is clocked on its rising edge.
REQ-009 Port rst, input, 1, synchronous, active-high reset.
REQ-010 Port link_raw, input, 1, asynchronous comparator output from the received power link.
REQ-011 Port link, output, 1, synchronised and deglitched link, fed to the PLL phase detector.
REQ-012 Port swiptAlive, output, 1, high while valid link edges keep arriving.
REQ-013 Port freq_rdy, output, 1, high while the link is locked in frequency.
REQ-014 Port period, output, 32, last accepted period in clk cycles.
REQ-015 Port f_meas, output, 32, measured frequency in Hz; present only with LINK_COND_FREQ_EN.

Function
REQ-016 link_raw SHALL pass through a two-flop synchroniser before any other use.
REQ-017 link SHALL change only after FILT_LEN consecutive synchronised samples equal the new level; latency from link_raw to link is 2+FILT_LEN cycles.
REQ-018 A free-running 32-bit edge counter SHALL count cycles between rising edges of link, restart at 1 on each edge, and saturate at 32'hFFFF_FFFF.
REQ-019 On a rising edge, a count within [MIN_PER, MAX_PER] is accepted: period SHALL load the count on the next cycle.
REQ-020 On a rising edge, a count outside [MIN_PER, MAX_PER] SHALL be discarded: period is unchanged and the stable counter is cleared.
REQ-021 FSM states: IDLE, ACQUIRE, LOCKED.
REQ-022 IDLE to ACQUIRE on the first rising edge; that edge only starts the count and no period is accepted.
REQ-023 ACQUIRE: each accepted period within TOL_CYC of the previous accepted period increments the stable counter; any other period resets it to 0.
REQ-024 ACQUIRE to LOCKED when the stable counter reaches LOCK_CNT.
REQ-025 LOCKED to ACQUIRE on one unstable or out-of-range period, with the stable counter cleared.
REQ-026 Any state to IDLE when the edge counter reaches TIMEOUT_CYC.
REQ-027 Timeout has priority over a rising edge in the same cycle.
REQ-028 swiptAlive = 1 in ACQUIRE and LOCKED; freq_rdy = 1 only in LOCKED.
REQ-029 Both flags are registered, and update one cycle after the FSM transition.
REQ-030 Tolerance comparison SHALL use an unsigned absolute difference, so there is no wrap for either ordering of the two periods.

Reset
REQ-031 While rst = 1: FSM in IDLE; link = 0; swiptAlive = 0; freq_rdy = 0; period = 0; f_meas = 0; synchroniser, filter, edge counter and stable counter cleared.
REQ-032 rst asserted mid-measurement SHALL abort any division in progress, and no stale result may appear after release.

Configuration
REQ-033 With LINK_COND_FREQ_EN defined, each accepted period starts a sequential 32-bit divide CLK_HZ/period.
REQ-034 The quotient SHALL load f_meas at completion, within 34 cycles.
REQ-035 A new period arriving during a divide SHALL restart it.
REQ-036 Without LINK_COND_FREQ_EN, the f_meas port, the divider and all their logic SHALL be absent.

Structure
REQ-037 Package link_cond_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-038 The divider SHALL be a sub-module seq_div (start/busy/done handshake, 32-bit unsigned), instantiated only under LINK_COND_FREQ_EN.

Verification
REQ-039 41 kHz square wave on link_raw -> period = 2439; freq_rdy rises after the 5th rising edge; f_meas = 41000 (macro on).
REQ-040 3-cycle glitches on a steady low link_raw (FILT_LEN = 4) -> link stays 0 and no edges are counted.
REQ-041 Locked at 41 kHz, then link_raw held constant -> swiptAlive and freq_rdy fall 250000 cycles after the last edge; FSM returns to IDLE.
REQ-042 Locked, then one period of 2460 cycles -> ACQUIRE, freq_rdy = 0; relock after 4 further stable periods.
REQ-043 Input at 200 kHz (500 cycles) -> period stays 0 and freq_rdy never asserts; swiptAlive = 1 from the first edge.
REQ-044 rst pulsed during a divide -> all outputs 0 next cycle; after release, f_meas updates only from new periods.
